// File: rtl/axi4lite_regbank_responder.sv
// -----------------------------------------------------------------------------
// axi4lite_regbank_responder
//
// AXI4-Lite subordinate that terminates the AW/W/B/AR/R channels in a
// word-addressed register bank. Registers 0..NUM_REGS-2 are read/write. The
// top index (NUM_REGS-1) is a read-only view of the hw_status input.
// Out-of-range accesses and writes to the status index complete with SLVERR.
//
// Ports
//   ACLK, ARESET          clock (rising edge), synchronous active-high reset
//   AW*/W*/B*             write address, write data and write response channels
//   AR*/R*                read address and read data channels
//   hw_status             value returned for reads of index NUM_REGS-1
//   reg_wr_pulse          1-cycle pulse on every OKAY register write
//   reg_wr_idx            index written, valid while reg_wr_pulse=1
//   reg_flat              registers concatenated, reg0 in LSBs, top = hw_status
// -----------------------------------------------------------------------------
module axi4lite_regbank_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_REGS   = 12
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    input  logic [DATA_WIDTH-1:0]          hw_status,
    output logic                           reg_wr_pulse,
    output logic [ADDR_WIDTH-3:0]          reg_wr_idx,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_flat
);

    localparam int                IDX_W       = ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0]  STATUS_IDX  = IDX_W'(NUM_REGS - 1);
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Byte-lane bits of the addresses carry no information for word access.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};

    logic [DATA_WIDTH-1:0] regs [NUM_REGS-1];

    // -------------------------------------------------------------------------
    // Write path
    // -------------------------------------------------------------------------
    w_state_t              w_state, w_next;
    logic                  aw_held, w_held;
    logic [IDX_W-1:0]      aw_idx_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic                  aw_hs, w_hs, commit, wr_ok;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;

    assign BVALID  = (w_state == W_RESP);
    assign AWREADY = !ARESET && !aw_held && !BVALID;
    assign WREADY  = !ARESET && !w_held && !BVALID;
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;

    // A handshake in the current cycle counts as "held", so a same-cycle AW+W
    // commits on this edge and BVALID rises one cycle after the handshake.
    assign wr_idx  = aw_held ? aw_idx_q : AWADDR[ADDR_WIDTH-1:2];
    assign wr_data = w_held ? w_data_q : WDATA;
    assign commit  = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_ok   = (wr_idx < STATUS_IDX);

    always_ff @(posedge ACLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of block ordering.
        if (ARESET) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves w_next unassigned,
        // which would otherwise infer a latch.
        w_next = w_state;
        case (w_state)
            W_IDLE: if (commit) w_next = W_RESP;
            W_RESP: if (BREADY) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_idx_q     <= '0;
            w_data_q     <= '0;
            BRESP        <= RESP_OKAY;
            reg_wr_pulse <= 1'b0;
            reg_wr_idx   <= '0;
            // NOTE: the bank is small and its reset value is architecturally
            // visible, so it is flop-based and cleared rather than a RAM.
            for (int i = 0; i < NUM_REGS - 1; i++) regs[i] <= '0;
        end else begin
            reg_wr_pulse <= 1'b0;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                BRESP   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                if (wr_ok) begin
                    reg_wr_pulse <= 1'b1;
                    reg_wr_idx   <= wr_idx;
                    for (int i = 0; i < NUM_REGS - 1; i++) begin
                        if (wr_idx == IDX_W'(i)) regs[i] <= wr_data;
                    end
                end
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= AWADDR[ADDR_WIDTH-1:2];
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= WDATA;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read path (independent of the write path; a read in the commit cycle
    // sees the pre-write register value)
    // -------------------------------------------------------------------------
    r_state_t              r_state, r_next;
    logic                  ar_hs;
    logic [IDX_W-1:0]      ar_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            rd_resp;

    assign RVALID  = (r_state == R_DATA);
    assign ARREADY = !ARESET && !RVALID;
    assign ar_hs   = ARVALID && ARREADY;
    assign ar_idx  = ARADDR[ADDR_WIDTH-1:2];

    always_ff @(posedge ACLK) begin
        if (ARESET) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: if (ar_hs)  r_next = R_DATA;
            R_DATA: if (RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        if (ar_idx > STATUS_IDX) begin
            rd_resp = RESP_SLVERR;
        end else if (ar_idx == STATUS_IDX) begin
            rd_data = hw_status;
        end else begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (ar_idx == IDX_W'(i)) rd_data = regs[i];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            RDATA <= '0;
            RRESP <= RESP_OKAY;
        end else if (ar_hs) begin
            RDATA <= rd_data;
            RRESP <= rd_resp;
        end
    end

    // -------------------------------------------------------------------------
    // Flattened register view for local logic
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < NUM_REGS - 1; g++) begin : g_flat
        assign reg_flat[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end
    assign reg_flat[(NUM_REGS-1)*DATA_WIDTH +: DATA_WIDTH] = hw_status;

endmodule

// File: tb/tb_axi4lite_regbank_responder.sv
// -----------------------------------------------------------------------------
// tb_axi4lite_regbank_responder
//
// Directed bench for axi4lite_regbank_responder (DATA_WIDTH=32, ADDR_WIDTH=6,
// NUM_REGS=12). Inputs change 1 ns after the rising edge and outputs are
// sampled there as well, so every sample sees settled post-edge values.
// -----------------------------------------------------------------------------
module tb_axi4lite_regbank_responder;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NR = 12;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic [AW-1:0]     AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [DW-1:0]     WDATA;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [AW-1:0]     ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [DW-1:0]     RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;
    logic [DW-1:0]     hw_status;
    logic              reg_wr_pulse;
    logic [AW-3:0]     reg_wr_idx;
    logic [NR*DW-1:0]  reg_flat;

    int checks = 0;
    int errors = 0;

    axi4lite_regbank_responder #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_REGS  (NR)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .AWADDR      (AWADDR),
        .AWVALID     (AWVALID),
        .AWREADY     (AWREADY),
        .WDATA       (WDATA),
        .WVALID      (WVALID),
        .WREADY      (WREADY),
        .BRESP       (BRESP),
        .BVALID      (BVALID),
        .BREADY      (BREADY),
        .ARADDR      (ARADDR),
        .ARVALID     (ARVALID),
        .ARREADY     (ARREADY),
        .RDATA       (RDATA),
        .RRESP       (RRESP),
        .RVALID      (RVALID),
        .RREADY      (RREADY),
        .hw_status   (hw_status),
        .reg_wr_pulse(reg_wr_pulse),
        .reg_wr_idx  (reg_wr_idx),
        .reg_flat    (reg_flat)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Single read with RREADY=1: data one cycle after AR, RVALID low after.
    task automatic read_chk(input string tag, input logic [AW-1:0] a,
                            input logic [DW-1:0] ed, input logic [1:0] er);
        ARADDR  = a;
        ARVALID = 1'b1;
        RREADY  = 1'b1;
        tick();
        ARVALID = 1'b0;
        check({tag, " rvalid"}, 64'(RVALID), 64'd1);
        check({tag, " rdata"},  64'(RDATA),  64'(ed));
        check({tag, " rresp"},  64'(RRESP),  64'(er));
        tick();
        check({tag, " rvalid drop"}, 64'(RVALID), 64'd0);
    endtask

    initial begin
        ARESET = 1'b1; AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WVALID = 1'b0;
        BREADY = 1'b0; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0; hw_status = '0;

        // ---- Reset state ----
        tick();
        tick();
        check("rst bvalid", 64'(BVALID), 64'd0);
        check("rst rvalid", 64'(RVALID), 64'd0);
        check("rst bresp",  64'(BRESP),  64'd0);
        check("rst rresp",  64'(RRESP),  64'd0);
        check("rst rdata",  64'(RDATA),  64'd0);
        check("rst pulse",  64'(reg_wr_pulse), 64'd0);
        check("rst flat",   64'(|reg_flat), 64'd0);
        check("rst readies", 64'({AWREADY, WREADY, ARREADY}), 64'd0);
        ARESET = 1'b0;
        #1;
        check("post rst readies", 64'({AWREADY, WREADY, ARREADY}), 64'h7);

        // ---- 1: same-cycle AW+W to 0x04 ----
        AWADDR = 6'h04; AWVALID = 1'b1; WDATA = 32'hDEADBEEF; WVALID = 1'b1; BREADY = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        check("t1 bvalid", 64'(BVALID), 64'd1);
        check("t1 bresp",  64'(BRESP),  64'd0);
        check("t1 pulse",  64'(reg_wr_pulse), 64'd1);
        check("t1 idx",    64'(reg_wr_idx),   64'd1);
        tick();
        check("t1 bvalid drop", 64'(BVALID), 64'd0);
        check("t1 pulse drop",  64'(reg_wr_pulse), 64'd0);
        check("t1 reg1", 64'(reg_flat[2*DW-1:DW]), 64'hDEADBEEF);
        read_chk("t1 rd04", 6'h04, 32'hDEADBEEF, 2'b00);

        // ---- 2: W three cycles ahead of AW(0x08) ----
        WDATA = 32'h12345678; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        check("t2 wready drop", 64'(WREADY), 64'd0);
        check("t2 awready",     64'(AWREADY), 64'd1);
        tick();
        tick();
        check("t2 wready held", 64'(WREADY), 64'd0);
        check("t2 no early b",  64'(BVALID), 64'd0);
        AWADDR = 6'h08; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        check("t2 bvalid", 64'(BVALID), 64'd1);
        check("t2 bresp",  64'(BRESP),  64'd0);
        check("t2 idx",    64'(reg_wr_idx), 64'd2);
        tick();
        check("t2 single b", 64'(BVALID), 64'd0);
        check("t2 reg2", 64'(reg_flat[3*DW-1:2*DW]), 64'h12345678);
        check("t2 wready back", 64'(WREADY), 64'd1);

        // ---- 3: status register and out-of-range ----
        AWADDR = 6'h2C; AWVALID = 1'b1; WDATA = 32'hFFFFFFFF; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        check("t3 bvalid", 64'(BVALID), 64'd1);
        check("t3 bresp",  64'(BRESP),  64'd2);
        check("t3 no pulse", 64'(reg_wr_pulse), 64'd0);
        tick();
        hw_status = 32'hA5A5A5A5;
        ARADDR = 6'h2C; ARVALID = 1'b1; RREADY = 1'b0;
        tick();
        ARVALID = 1'b0;
        hw_status = 32'h0;  // RDATA must keep the value sampled at AR
        tick();
        check("t3 status rdata", 64'(RDATA), 64'hA5A5A5A5);
        check("t3 status rresp", 64'(RRESP), 64'd0);
        RREADY = 1'b1;
        tick();
        check("t3 status rvalid drop", 64'(RVALID), 64'd0);
        read_chk("t3 rd30", 6'h30, 32'h0, 2'b10);

        // ---- 4: back-pressure on B and R (write reg3=0x55, read 0x04) ----
        BREADY = 1'b0; RREADY = 1'b0;
        AWADDR = 6'h0C; AWVALID = 1'b1; WDATA = 32'h55; WVALID = 1'b1;
        ARADDR = 6'h04; ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        check("t4 pulse idx", 64'({reg_wr_pulse, reg_wr_idx}), 64'h13);
        for (int i = 0; i < 5; i++) begin
            check("t4 b hold", 64'({BVALID, BRESP}), 64'h4);
            check("t4 r hold", 64'({RVALID, RRESP, RDATA}), {30'd0, 1'b1, 2'b00, 32'hDEADBEEF});
            check("t4 readies", 64'({AWREADY, WREADY, ARREADY}), 64'd0);
            tick();
        end
        RREADY = 1'b1;
        tick();
        check("t4 rvalid drop", 64'(RVALID), 64'd0);
        check("t4 bvalid still", 64'(BVALID), 64'd1);
        check("t4 reg3", 64'(reg_flat[4*DW-1:3*DW]), 64'h55);

        // ---- 6: reset while BVALID=1 ----
        ARESET = 1'b1;
        tick();
        check("t6 bvalid", 64'(BVALID), 64'd0);
        check("t6 reg3",   64'(reg_flat[4*DW-1:3*DW]), 64'd0);
        check("t6 reg1",   64'(reg_flat[2*DW-1:DW]), 64'd0);
        check("t6 readies in rst", 64'({AWREADY, WREADY, ARREADY}), 64'd0);
        ARESET = 1'b0;
        #1;
        check("t6 readies after", 64'({AWREADY, WREADY, ARREADY}), 64'h7);
        read_chk("t6 rd0c", 6'h0C, 32'h0, 2'b00);

        // ---- 5: read of reg0 in the same cycle as its write commit ----
        BREADY = 1'b1; RREADY = 1'b1;
        AWADDR = 6'h00; AWVALID = 1'b1; WDATA = 32'h11; WVALID = 1'b1;
        ARADDR = 6'h00; ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        check("t5 rdata old", 64'(RDATA), 64'd0);
        check("t5 bvalid",    64'(BVALID), 64'd1);
        check("t5 pulse idx", 64'({reg_wr_pulse, reg_wr_idx}), 64'h10);
        tick();
        read_chk("t5 rd00", 6'h00, 32'h11, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
